// File: rtl/aurora_pkg.sv
// Shared definitions for the Aurora link controller: state codes, timer width
// and GPIO_LED bit positions, reused by the board top and benches.
package aurora_pkg;

  localparam int TMR_W = 20;

  typedef enum logic [2:0] {
    WAIT_PLL = 3'd0,
    GT_RST   = 3'd1,
    CORE_RST = 3'd2,
    WAIT_UP  = 3'd3,
    UP       = 3'd4,
    FAIL     = 3'd5
  } link_state_e;

  localparam int LED_LINK_OK   = 0;
  localparam int LED_PLL_LOCK  = 1;
  localparam int LED_FAIL      = 2;
  localparam int LED_STATE_LSB = 3;
  localparam int LED_RETRY_LSB = 6;

  function automatic logic gt_reset_of(link_state_e s);
    return (s == WAIT_PLL) || (s == GT_RST) || (s == FAIL);
  endfunction

  function automatic logic core_reset_of(link_state_e s);
    return (s != WAIT_UP) && (s != UP);
  endfunction

endpackage

// File: rtl/aurora_link_ctrl.sv
// Aurora bring-up sequencer: PLL wait, GT and core reset phases, channel-up
// timeout with bounded retries, link supervision and error/status reporting.
module aurora_link_ctrl
  import aurora_pkg::*;
#(
  parameter int N_LANE          = 1,
  parameter int GT_RST_CYCLES   = 128,
  parameter int CORE_RST_CYCLES = 64,
  parameter int UP_TIMEOUT      = 2**20,
  parameter int MAX_RETRY       = 7
) (
  input  logic              user_clk,
  input  logic              sys_rst_n,
  input  logic              pll_locked,
  input  logic [N_LANE-1:0] lane_up,
  input  logic              channel_up,
  input  logic              hard_err,
  input  logic              soft_err,
  input  logic              retry_req,
  output logic              gt_reset,
  output logic              aurora_reset,
  output logic              link_ok,
  output logic [3:0]        retry_cnt,
  output logic [15:0]       soft_err_cnt,
  output logic [7:0]        GPIO_LED
);

  localparam logic [TMR_W-1:0] GT_LOAD   = TMR_W'(GT_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] CORE_LOAD = TMR_W'(CORE_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] UP_LOAD   = TMR_W'(UP_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  link_state_e      state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [3:0]       retry_nxt, retry_inc;
  logic [15:0]      soft_nxt;
  logic [7:0]       led_nxt;
  logic             link_good;

  assign link_good = channel_up && (&lane_up);
  assign retry_inc = (retry_cnt == 4'd15) ? retry_cnt : retry_cnt + 4'd1;

  // Loss of PLL lock overrides every other transition; a completed channel-up
  // in WAIT_UP wins over both a coincident hard error and the timeout.
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    if (state != WAIT_PLL && !pll_locked) begin
      state_nxt = WAIT_PLL;
    end else begin
      case (state)
        WAIT_PLL: if (pll_locked) state_nxt = GT_RST;
        GT_RST:   if (timer == '0) state_nxt = CORE_RST;
        CORE_RST: if (timer == '0) state_nxt = WAIT_UP;
        WAIT_UP: begin
          if (link_good) begin
            state_nxt = UP;
            retry_nxt = 4'd0;
          end else if (timer == '0) begin
            retry_nxt = retry_inc;
            state_nxt = (retry_inc == RETRY_MAX) ? FAIL : GT_RST;
          end
        end
        UP: begin
          if (hard_err || !link_good) begin
            state_nxt = GT_RST;
            retry_nxt = retry_inc;
          end
        end
        FAIL: begin
          if (retry_req) begin
            state_nxt = GT_RST;
            retry_nxt = 4'd0;
          end
        end
        default: state_nxt = WAIT_PLL;
      endcase
    end
  end

  // The single timer is reloaded on every state change and counts down to zero.
  always_comb begin
    timer_nxt = timer;
    if (state_nxt != state) begin
      case (state_nxt)
        GT_RST:   timer_nxt = GT_LOAD;
        CORE_RST: timer_nxt = CORE_LOAD;
        WAIT_UP:  timer_nxt = UP_LOAD;
        default:  timer_nxt = '0;
      endcase
    end else if (timer != '0) begin
      timer_nxt = timer - TMR_W'(1);
    end
  end

  always_comb begin
    soft_nxt = soft_err_cnt;
    if (state == WAIT_UP && state_nxt == UP)
      soft_nxt = 16'd0;
    else if (state == UP && soft_err && soft_err_cnt != 16'hFFFF)
      soft_nxt = soft_err_cnt + 16'd1;
  end

  always_comb begin
    led_nxt = '0;
    led_nxt[LED_LINK_OK]            = (state_nxt == UP);
    led_nxt[LED_PLL_LOCK]           = pll_locked;
    led_nxt[LED_FAIL]               = (state_nxt == FAIL);
    led_nxt[LED_STATE_LSB +: 3]     = state_nxt;
    led_nxt[LED_RETRY_LSB +: 2]     = retry_nxt[1:0];
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge user_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= WAIT_PLL;
      timer        <= '0;
      retry_cnt    <= 4'd0;
      soft_err_cnt <= 16'd0;
      gt_reset     <= 1'b1;
      aurora_reset <= 1'b1;
      link_ok      <= 1'b0;
      GPIO_LED     <= 8'h00;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      retry_cnt    <= retry_nxt;
      soft_err_cnt <= soft_nxt;
      gt_reset     <= gt_reset_of(state_nxt);
      aurora_reset <= core_reset_of(state_nxt);
      link_ok      <= (state_nxt == UP);
      GPIO_LED     <= led_nxt;
    end
  end

endmodule

// File: doc/aurora_link_ctrl.md
AURORA_LINK_CTRL -- requirements
Module: aurora_link_ctrl

Interface
REQ-001 SHALL have parameter N_LANE, default 1, number of Aurora lanes monitored.
REQ-002 SHALL have parameter GT_RST_CYCLES, default 128, cycles gt_reset is held per attempt.
REQ-003 SHALL have parameter CORE_RST_CYCLES, default 64, cycles aurora_reset is held after gt_reset releases.
REQ-004 SHALL have parameter UP_TIMEOUT, default 2**20, WAIT_UP cycles allowed before a retry.
REQ-005 SHALL have parameter MAX_RETRY, default 7, consecutive failed attempts before FAIL.
REQ-006 SHALL have port user_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port pll_locked, input, 1, GT PLL lock status.
REQ-009 SHALL have port lane_up, input, N_LANE, per-lane up status.
REQ-010 SHALL have port channel_up, input, 1, Aurora channel up status.
REQ-011 SHALL have ports hard_err and soft_err, input, 1 each, single-cycle error pulses.
REQ-012 SHALL have port retry_req, input, 1, single-cycle pulse that restarts from FAIL.
REQ-013 SHALL have ports gt_reset and aurora_reset, output, 1 each, active-high resets to the GT and the core.
REQ-014 SHALL have port link_ok, output, 1, high only in state UP.
REQ-015 SHALL have port retry_cnt, output, 4, failed attempts since the last UP.
REQ-016 SHALL have port soft_err_cnt, output, 16, saturating soft-error count.
REQ-017 SHALL have port GPIO_LED, output, 8, status display.

Function
REQ-018 SHALL implement states WAIT_PLL, GT_RST, CORE_RST, WAIT_UP, UP, FAIL, each encoded in 3 bits.
REQ-019 SHALL drive gt_reset=1 in WAIT_PLL, GT_RST, and FAIL, and gt_reset=0 in all other states.
REQ-020 SHALL drive aurora_reset=1 in WAIT_PLL, GT_RST, CORE_RST, and FAIL, and aurora_reset=0 in WAIT_UP and UP.
REQ-021 SHALL drive all outputs from registers, with no combinational path from inputs to outputs.
REQ-022 WAIT_PLL SHALL go to GT_RST on the first cycle pll_locked=1.
REQ-023 GT_RST SHALL last exactly GT_RST_CYCLES cycles, then go to CORE_RST.
REQ-024 CORE_RST SHALL last exactly CORE_RST_CYCLES cycles, then go to WAIT_UP.
REQ-025 WAIT_UP SHALL go to UP when channel_up=1 and every lane_up bit is 1 in the same cycle; it SHALL then clear retry_cnt.
REQ-026 If the WAIT_UP timer reaches UP_TIMEOUT, the block SHALL increment retry_cnt, go to FAIL when the new value equals MAX_RETRY, and otherwise go to GT_RST.
REQ-027 UP SHALL go to GT_RST on hard_err=1, or on channel_up=0, or on any lane_up bit 0, and SHALL increment retry_cnt.
REQ-028 FAIL SHALL hold until retry_req=1, then clear retry_cnt and go to GT_RST; retry_req SHALL be ignored in all other states.
REQ-029 pll_locked=0 in any state other than WAIT_PLL SHALL force WAIT_PLL next cycle, with no retry_cnt change; this has priority over all other transitions.
REQ-030 If hard_err and the success condition coincide in WAIT_UP, the block SHALL take UP.
REQ-031 A single down-counter, 20 bits, SHALL time all states; it SHALL be reloaded on every state entry.
REQ-032 retry_cnt SHALL saturate at 15.
REQ-033 soft_err_cnt SHALL increment on soft_err only while in UP, and SHALL hold at 16'hFFFF.
REQ-034 soft_err_cnt SHALL clear on entry to UP from WAIT_UP.
REQ-035 GPIO_LED SHALL map as follows: bit[0]=link_ok, bit[1]=pll_locked (registered), bit[2]=FAIL, bits[5:3]=state code, bits[7:6]=retry_cnt[1:0].

Reset
REQ-036 Asserting sys_rst_n=0 SHALL immediately give state=WAIT_PLL, gt_reset=1, aurora_reset=1, link_ok=0, retry_cnt=0, soft_err_cnt=0, GPIO_LED=8'h00, and counter=0.
REQ-037 Reset mid-operation SHALL abandon the attempt with no residual counts.
REQ-038 Deassertion of sys_rst_n SHALL be synchronised externally, with the first active edge after release evaluating WAIT_PLL.

Structure
REQ-039 State encodings and the LED bit-position constants SHALL reside in shared package aurora_pkg, for reuse by the board top and benches.
REQ-040 The block SHALL be a single module with no sub-modules; the timer is inline.

Verification (GT_RST_CYCLES=4, CORE_RST_CYCLES=8, UP_TIMEOUT=100, MAX_RETRY=3, N_LANE=2)
REQ-041 Bring-up: pll_locked=1 at cycle 0, lane_up=2'b11 and channel_up=1 at cycle 20 -> gt_reset falls at cycle 5, aurora_reset falls at cycle 13, link_ok=1 at cycle 21, retry_cnt=0.
REQ-042 Timeout: channel_up held 0 -> three WAIT_UP timeouts, retry_cnt 1,2,3, then FAIL with GPIO_LED[2]=1 and both resets high; retry_req -> GT_RST with retry_cnt=0.
REQ-043 Link drop: in UP, hard_err pulse -> link_ok=0 next cycle, gt_reset=1, retry_cnt=1; re-up -> retry_cnt=0.
REQ-044 PLL loss: pll_locked=0 during CORE_RST -> WAIT_PLL next cycle with retry_cnt unchanged; relock -> full GT_RST sequence.
REQ-045 Counters: 70000 soft_err pulses in UP -> soft_err_cnt=16'hFFFF; soft_err outside UP leaves the count unchanged.
REQ-046 Async reset: sys_rst_n low for 3 ns between clock edges in UP -> all outputs at reset values before the next edge.
